// File: rtl/mac_requant.sv
// Requantizer for the MAC accumulator stream: round-half-up, then saturate,
// in a two-stage elastic pipeline with a per-sample clamp flag and a running clamp count.
module mac_requant #(
   parameter int unsigned int_in_p        = 10,
   parameter int unsigned frac_in_p       = 22,
   parameter int unsigned int_out_p       = 1,
   parameter int unsigned frac_out_p      = 11,
   parameter int unsigned sat_cnt_width_p = 16
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic                                valid_i,
   output logic                                ready_o,
   input  logic [int_in_p+frac_in_p-1:0]       data_i,
   output logic                                valid_o,
   input  logic                                ready_i,
   output logic [int_out_p+frac_out_p-1:0]     data_o,
   output logic                                sat_o,
   output logic [sat_cnt_width_p-1:0]          sat_count_o,
   input  logic                                clear_count_i
);

   localparam int unsigned in_w  = int_in_p + frac_in_p;
   localparam int unsigned out_w = int_out_p + frac_out_p;
   localparam int unsigned sh_w  = frac_in_p - frac_out_p;
   localparam int unsigned r_w   = int_in_p + frac_out_p + 1;

   logic             s1_valid;
   logic [r_w-1:0]   s1_r;
   logic             s1_adv;
   logic             s2_adv;

   logic [in_w:0]    round_sum;
   logic [r_w-1:0]   round_r;
   logic [r_w-out_w:0] s1_top;
   logic             fits;
   logic             sat_c;
   logic [out_w-1:0] sat_data;

   // Each stage moves when it is empty or its successor takes its contents.
   assign s2_adv  = !valid_o || ready_i;
   assign s1_adv  = !s1_valid || s2_adv;
   assign ready_o = s1_adv;

   // Round half up: add half an output LSB to the sign-extended word, keep the upper bits.
   always_comb begin
      round_sum = {data_i[in_w-1], data_i} + ((in_w+1)'(1) << (sh_w - 1));
      round_r   = round_sum[in_w:sh_w];
   end

   // Value fits when every bit above the output sign bit matches it.
   always_comb begin
      s1_top   = s1_r[r_w-1:out_w-1];
      fits     = (&s1_top) || !(|s1_top);
      sat_c    = !fits;
      sat_data = s1_r[out_w-1:0];
      if (!fits) begin
         sat_data = s1_r[r_w-1] ? {1'b1, {(out_w-1){1'b0}}} : {1'b0, {(out_w-1){1'b1}}};
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         s1_valid <= 1'b0;
         s1_r     <= '0;
      end else if (s1_adv) begin
         s1_valid <= valid_i;
         if (valid_i) begin
            s1_r <= round_r;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         valid_o <= 1'b0;
         data_o  <= '0;
         sat_o   <= 1'b0;
      end else if (s2_adv) begin
         valid_o <= s1_valid;
         if (s1_valid) begin
            data_o <= sat_data;
            sat_o  <= sat_c;
         end
      end
   end

   // Clamp counter sticks at all-ones; clear takes priority over an increment.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         sat_count_o <= '0;
      end else if (clear_count_i) begin
         sat_count_o <= '0;
      end else if (valid_o && ready_i && sat_o && !(&sat_count_o)) begin
         sat_count_o <= sat_count_o + sat_cnt_width_p'(1);
      end
   end

endmodule

// File: tb/tb_mac_requant.sv
// Bench for mac_requant: directed vector table, counter/backpressure/reset sequences,
// and randomized traffic checked against an arithmetic reference with a scoreboard.
module tb_mac_requant;

   localparam int IW = 32;
   localparam int OW = 12;
   localparam int SH = 11;
   localparam longint MAXV = (longint'(1) << (OW-1)) - 1;
   localparam longint MINV = -(longint'(1) << (OW-1));

   typedef struct packed {
      logic [OW-1:0] d;
      logic          s;
   } exp_t;

   typedef struct {
      logic [IW-1:0] din;
      logic [OW-1:0] dout;
      logic          sat;
   } vec_t;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          valid_i;
   logic          ready_o;
   logic [IW-1:0] data_i;
   logic          valid_o;
   logic          ready_i;
   logic [OW-1:0] data_o;
   logic          sat_o;
   logic [15:0]   sat_count_o;
   logic          clear_count_i;

   logic          ready_o2;
   logic          valid_o2;
   logic [OW-1:0] data_o2;
   logic          sat_o2;
   logic [1:0]    cnt2;

   int checks = 0;
   int errors = 0;
   int n_in   = 0;
   int n_out  = 0;
   int exp_cnt  = 0;
   int exp_cnt2 = 0;
   bit stall_v  = 1'b0;
   exp_t q[$];
   vec_t tbl[9];

   always #5 clk_i = ~clk_i;

   mac_requant dut (
      .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
      .sat_o(sat_o), .sat_count_o(sat_count_o), .clear_count_i(clear_count_i)
   );

   mac_requant #(.sat_cnt_width_p(2)) dut_c2 (
      .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o2),
      .data_i(data_i), .valid_o(valid_o2), .ready_i(ready_i), .data_o(data_o2),
      .sat_o(sat_o2), .sat_count_o(cnt2), .clear_count_i(clear_count_i)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: exact signed arithmetic on the real value, then clamp.
   function automatic exp_t model(input logic [IW-1:0] din);
      longint x;
      longint r;
      exp_t   e;
      x = longint'($signed(din));
      r = (x + (longint'(1) << (SH-1))) >>> SH;
      if (r > MAXV) begin
         e.d = OW'(MAXV); e.s = 1'b1;
      end else if (r < MINV) begin
         e.d = OW'(MINV); e.s = 1'b1;
      end else begin
         e.d = OW'(r);    e.s = 1'b0;
      end
      return e;
   endfunction

   function automatic logic [IW-1:0] rand_word();
      logic [31:0] t;
      t = $urandom;
      case ($urandom % 4)
         0:       return t;
         1:       return {{10{t[22]}}, t[21:0]};
         2:       return {{10{t[22]}}, t[21:11], 11'h400};
         default: return (t[31] ? 32'h003FF800 : 32'hFFC00000)
                         + 32'($urandom_range(4095)) - 32'd2048;
      endcase
   endfunction

   // Scoreboard: sampled on the falling edge, transfers take effect on the next rising edge.
   always @(negedge clk_i) begin
      exp_t e;
      logic exp_rdy;
      if (!reset_i) begin
         q.delete();
         exp_cnt  = 0;
         exp_cnt2 = 0;
         stall_v  = 1'b0;
         chk("rst_valid_o", 32'(valid_o), 32'd0);
         chk("rst_sat_count", 32'(sat_count_o), 32'd0);
      end else begin
         chk("sat_count", 32'(sat_count_o), 32'(exp_cnt));
         chk("sat_count_w2", 32'(cnt2), 32'(exp_cnt2));
         exp_rdy = (q.size() < 2) || ready_i;
         chk("ready_o", 32'(ready_o), 32'(exp_rdy));
         chk("ready_o_w2", 32'(ready_o2), 32'(exp_rdy));
         if (stall_v) chk("stall_valid_held", 32'(valid_o), 32'd1);
         if (valid_o) begin
            if (q.size() == 0) begin
               chk("spurious_valid_o", 32'(valid_o), 32'd0);
            end else begin
               chk("data_o", 32'(data_o), 32'(q[0].d));
               chk("sat_o", 32'(sat_o), 32'(q[0].s));
               chk("data_o_w2", 32'({valid_o2, data_o2, sat_o2}), 32'({1'b1, q[0].d, q[0].s}));
            end
         end
         stall_v = valid_o && !ready_i;
         e = '0;
         if (valid_o && ready_i && q.size() > 0) begin
            e = q.pop_front();
            n_out++;
         end
         if (clear_count_i) begin
            exp_cnt  = 0;
            exp_cnt2 = 0;
         end else if (valid_o && ready_i && e.s) begin
            if (exp_cnt < 65535) exp_cnt++;
            if (exp_cnt2 < 3)    exp_cnt2++;
         end
         if (valid_i && ready_o) begin
            q.push_back(model(data_i));
            n_in++;
         end
      end
   end

   task automatic send(input logic [IW-1:0] d);
      bit took;
      int n;
      took = 1'b0;
      n = 0;
      valid_i = 1'b1;
      data_i  = d;
      while (!took && n < 200) begin
         @(negedge clk_i);
         took = ready_o;
         @(posedge clk_i); #1;
         n++;
      end
      valid_i = 1'b0;
      chk("send_accepted", 32'(took), 32'd1);
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(negedge clk_i);
         lat++;
      end while (!valid_o && lat < 20);
      chk("wait_valid_o", 32'(valid_o), 32'd1);
   endtask

   initial begin
      int   lat;
      int   base_in;
      int   base_out;
      int   cyc;
      exp_t m;
      logic [IW-1:0] x;

      tbl[0] = '{32'h00200000, 12'h400, 1'b0};
      tbl[1] = '{32'h00000400, 12'h001, 1'b0};
      tbl[2] = '{32'h000003FF, 12'h000, 1'b0};
      tbl[3] = '{32'hFFFFFC00, 12'h000, 1'b0};
      tbl[4] = '{32'hFFFFFBFF, 12'hFFF, 1'b0};
      tbl[5] = '{32'h00400000, 12'h7FF, 1'b1};
      tbl[6] = '{32'h003FFC00, 12'h7FF, 1'b1};
      tbl[7] = '{32'hFF800000, 12'h800, 1'b1};
      tbl[8] = '{32'hFFC00000, 12'h800, 1'b0};

      valid_i = 1'b0; data_i = '0; ready_i = 1'b1; clear_count_i = 1'b0; reset_i = 1'b1;
      #1 reset_i = 1'b0;

      // Reset with input traffic offered
      valid_i = 1'b1;
      data_i  = 32'h00400000;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("reset_valid_o", 32'(valid_o), 32'd0);
      chk("reset_data_o", 32'(data_o), 32'd0);
      chk("reset_sat_count", 32'(sat_count_o), 32'd0);
      @(posedge clk_i); #1;
      reset_i = 1'b1;
      valid_i = 1'b0;
      @(negedge clk_i);
      chk("reset_ready_o", 32'(ready_o), 32'd1);
      @(posedge clk_i); #1;

      // Directed rounding and saturation vectors
      for (int i = 0; i < 9; i++) begin
         send(tbl[i].din);
         wait_out(lat);
         chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd2);
         chk($sformatf("tbl%0d_data", i), 32'(data_o), 32'(tbl[i].dout));
         chk($sformatf("tbl%0d_sat", i), 32'(sat_o), 32'(tbl[i].sat));
         @(posedge clk_i); #1;
      end
      @(negedge clk_i);
      chk("tbl_sat_count", 32'(sat_count_o), 32'd3);
      chk("tbl_sat_count_w2", 32'(cnt2), 32'd3);

      // Narrow counter sticks at all-ones
      @(posedge clk_i); #1;
      clear_count_i = 1'b1;
      @(posedge clk_i); #1;
      clear_count_i = 1'b0;
      for (int i = 0; i < 5; i++) send((i % 2) ? 32'hFF000000 : 32'h00800000);
      repeat (4) @(posedge clk_i);
      #1;
      @(negedge clk_i);
      chk("five_sat_count", 32'(sat_count_o), 32'd5);
      chk("five_sat_count_w2", 32'(cnt2), 32'd3);

      // Clear coincident with a saturated output transfer
      @(posedge clk_i); #1;
      ready_i = 1'b0;
      send(32'h00400000);
      repeat (3) @(posedge clk_i);
      #1;
      @(negedge clk_i);
      chk("hold_valid_o", 32'(valid_o), 32'd1);
      chk("pre_clear_count", 32'(sat_count_o), 32'd5);
      @(posedge clk_i); #1;
      ready_i = 1'b1;
      clear_count_i = 1'b1;
      @(posedge clk_i); #1;
      clear_count_i = 1'b0;
      @(negedge clk_i);
      chk("clear_wins", 32'(sat_count_o), 32'd0);
      chk("clear_wins_w2", 32'(cnt2), 32'd0);

      // Backpressure: fill with ready low, then drain with ready toggling
      @(posedge clk_i); #1;
      ready_i  = 1'b0;
      base_in  = n_in;
      base_out = n_out;
      fork
         for (int k = 0; k < 8; k++) send(rand_word());
         begin
            repeat (6) @(posedge clk_i);
            @(negedge clk_i);
            chk("bp_ready_low", 32'(ready_o), 32'd0);
            chk("bp_accepted_two", 32'(n_in - base_in), 32'd2);
            @(posedge clk_i); #1;
            cyc = 0;
            while (n_out - base_out < 8 && cyc < 200) begin
               ready_i = ~ready_i;
               @(posedge clk_i); #1;
               cyc++;
            end
            ready_i = 1'b1;
         end
      join
      chk("bp_in_count", 32'(n_in - base_in), 32'd8);
      chk("bp_out_count", 32'(n_out - base_out), 32'd8);

      // Randomized traffic with random backpressure and occasional clears
      base_out = n_out;
      fork
         for (int k = 0; k < 300; k++) begin
            repeat ($urandom % 3) begin
               @(posedge clk_i); #1;
            end
            send(rand_word());
         end
         begin
            cyc = 0;
            while (n_out - base_out < 300 && cyc < 20000) begin
               ready_i       = ($urandom % 3) != 0;
               clear_count_i = ($urandom % 32) == 0;
               @(posedge clk_i); #1;
               cyc++;
            end
            ready_i = 1'b1;
            clear_count_i = 1'b0;
         end
      join
      chk("rand_out_count", 32'(n_out - base_out), 32'd300);

      // Reset with two samples in flight
      send(32'h00400000);
      repeat (3) @(posedge clk_i);
      #1;
      ready_i = 1'b0;
      send(32'h00800000);
      send(32'h00200000);
      reset_i = 1'b0;
      #1;
      chk("midrst_valid_o", 32'(valid_o), 32'd0);
      chk("midrst_sat_count", 32'(sat_count_o), 32'd0);
      @(posedge clk_i); #1;
      reset_i = 1'b1;
      ready_i = 1'b1;
      x = rand_word();
      m = model(x);
      send(x);
      wait_out(lat);
      chk("midrst_latency", 32'(lat), 32'd2);
      chk("midrst_first_data", 32'(data_o), 32'(m.d));
      chk("midrst_first_sat", 32'(sat_o), 32'(m.s));
      repeat (3) @(posedge clk_i);
      #1;
      chk("final_queue_empty", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
